// File: rtl/mux2_rr_arbiter.sv
// Two-source valid/ready packet arbiter feeding one registered output stage.
// Grant is held for the whole packet; round-robin or fixed priority between packets.
module mux2_rr_arbiter #(
  parameter int unsigned DW = 8,
  parameter bit          RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i0_valid,
  output logic          i0_ready,
  input  logic [DW-1:0] i0_data,
  input  logic          i0_last,
  input  logic          i1_valid,
  output logic          i1_ready,
  input  logic [DW-1:0] i1_data,
  input  logic          i1_last,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [DW-1:0] y_data,
  output logic          y_last,
  output logic          y_src,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          y_valid_q, y_valid_d;
  logic [DW-1:0] y_data_q, y_data_d;
  logic          y_last_q, y_last_d;
  logic          y_src_q, y_src_d;

  logic load;
  logic g;
  logic req;
  logic acc;
  logic acc_last;

  always_comb begin
    load = ~y_valid_q | y_ready;
    g    = 1'b0;
    req  = 1'b0;
    unique case (state_q)
      LOCK0: begin
        g   = 1'b0;
        req = 1'b1;
      end
      LOCK1: begin
        g   = 1'b1;
        req = 1'b1;
      end
      default: begin
        req = i0_valid | i1_valid;
        if (i0_valid && i1_valid) g = RR ? prio_q : 1'b0;
        else                      g = i1_valid;
      end
    endcase
  end

  // Readys are gated by rst_n so nothing is acknowledged while reset is held.
  assign i0_ready = rst_n & req & load & ~g;
  assign i1_ready = rst_n & req & load &  g;

  assign acc      = g ? (i1_valid & i1_ready) : (i0_valid & i0_ready);
  assign acc_last = g ? i1_last : i0_last;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_src_d   = y_src_q;

    if (acc) begin
      if (acc_last) begin
        state_d = IDLE;
        if (RR) prio_d = ~g;
      end else begin
        state_d = g ? LOCK1 : LOCK0;
      end
    end

    if (load) begin
      y_valid_d = acc;
      if (acc) begin
        y_data_d = g ? i1_data : i0_data;
        y_last_d = acc_last;
        y_src_d  = g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_src_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_src_q   <= y_src_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign y_src   = y_src_q;
  assign busy    = (state_q != IDLE) | y_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus random packet traffic,
// checked every cycle against a packet-level reference model.
module tb_mux2_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       i0_valid, i0_ready, i0_last, i1_valid, i1_ready, i1_last;
  logic [7:0] i0_data, i1_data, y_data;
  logic       y_valid, y_ready, y_last, y_src, busy;

  logic       f_i0_valid, f_i0_ready, f_i0_last, f_i1_valid, f_i1_ready, f_i1_last;
  logic [7:0] f_i0_data, f_i1_data, f_y_data;
  logic       f_y_valid, f_y_ready, f_y_last, f_y_src, f_busy;

  mux2_rr_arbiter #(.DW(8), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i0_valid(i0_valid), .i0_ready(i0_ready), .i0_data(i0_data), .i0_last(i0_last),
    .i1_valid(i1_valid), .i1_ready(i1_ready), .i1_data(i1_data), .i1_last(i1_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .y_src(y_src), .busy(busy)
  );

  mux2_rr_arbiter #(.DW(8), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i0_valid(f_i0_valid), .i0_ready(f_i0_ready), .i0_data(f_i0_data), .i0_last(f_i0_last),
    .i1_valid(f_i1_valid), .i1_ready(f_i1_ready), .i1_data(f_i1_data), .i1_last(f_i1_last),
    .y_valid(f_y_valid), .y_ready(f_y_ready), .y_data(f_y_data), .y_last(f_y_last),
    .y_src(f_y_src), .busy(f_busy)
  );

  int checks = 0;
  int failures = 0;

  // Source-side stimulus state
  logic       sv[2];
  logic [7:0] sd[2];
  logic       sl[2];
  int         sbeat[2];
  int         slen[2];
  bit         acc[2];
  logic       last_r0, last_r1;

  // Reference model: packet owner (-1 = none), whose turn under contention,
  // and the single output slot.
  int         m_owner, m_turn, m_cand;
  bit         m_space, e_r0, e_r1;
  bit         m_ov, m_ol, m_os;
  logic [7:0] m_od;

  logic [7:0] exp_d;
  int         src_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    i0_valid = sv[0]; i0_data = sd[0]; i0_last = sl[0];
    i1_valid = sv[1]; i1_data = sd[1]; i1_last = sl[1];
  endtask

  task automatic new_beat(input int s);
    sd[s] = 8'($urandom);
    sl[s] = (sbeat[s] == slen[s] - 1);
  endtask

  task automatic model_reset();
    m_owner = -1; m_turn = 0;
    m_ov = 0; m_ol = 0; m_os = 0; m_od = '0;
  endtask

  task automatic model_comb();
    m_space = !m_ov || (y_ready === 1'b1);
    if (m_owner >= 0)          m_cand = m_owner;
    else if (sv[0] && sv[1])   m_cand = m_turn;
    else if (sv[0])            m_cand = 0;
    else if (sv[1])            m_cand = 1;
    else                       m_cand = -1;
    e_r0 = m_space && (m_cand == 0);
    e_r1 = m_space && (m_cand == 1);
  endtask

  task automatic model_edge();
    bit got;
    acc[0] = 0; acc[1] = 0;
    if (m_cand == 0 && e_r0 && sv[0]) acc[0] = 1;
    if (m_cand == 1 && e_r1 && sv[1]) acc[1] = 1;
    got = acc[0] || acc[1];
    if (m_space) begin
      m_ov = got;
      if (got) begin
        m_od = sd[m_cand]; m_ol = sl[m_cand]; m_os = (m_cand == 1);
      end
    end
    if (got) begin
      if (sl[m_cand]) begin
        m_owner = -1;
        m_turn  = 1 - m_cand;
      end else begin
        m_owner = m_cand;
      end
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    last_r0 = i0_ready;
    last_r1 = i1_ready;
    chk("i0_ready", i0_ready, e_r0);
    chk("i1_ready", i1_ready, e_r1);
    chk("y_valid", y_valid, m_ov);
    if (m_ov) begin
      chk("y_data", y_data, m_od);
      chk("y_last", y_last, m_ol);
      chk("y_src", y_src, m_os);
    end
    chk("busy", busy, (m_owner >= 0) || m_ov);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_advance();
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) begin
        if (sl[s]) begin
          sbeat[s] = 0;
          slen[s]  = $urandom_range(1, 4);
          sv[s]    = ($urandom_range(0, 2) != 0);
        end else begin
          sbeat[s]++;
          sv[s] = ($urandom_range(0, 3) != 0);
        end
        new_beat(s);
      end else if (!sv[s]) begin
        sv[s] = ($urandom_range(0, 2) == 0);
      end
    end
    y_ready = ($urandom_range(0, 3) != 0);
    apply();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b1; sbeat[s] = 0; slen[s] = 1; new_beat(s); acc[s] = 0;
    end
    y_ready = 1'b1;
    apply();
    f_i0_valid = 0; f_i0_data = '0; f_i0_last = 0;
    f_i1_valid = 0; f_i1_data = '0; f_i1_last = 0;
    f_y_ready = 1'b1;
    model_reset();

    // Reset with sources requesting
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_i0_ready", i0_ready, 0);
    chk("rst_i1_ready", i1_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Single-beat contention alternates starting from i0
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0) ? sd[0] : sd[1];
      cycle();
      chk("t2_y_valid", y_valid, 1);
      chk("t2_y_src", y_src, k % 2);
      chk("t2_y_data", y_data, exp_d);
      for (int s = 0; s < 2; s++) if (acc[s]) sd[s] = 8'($urandom);
      apply();
    end

    // Drain, then i0 4-beat packet with i1 arriving at beat 2
    sv[0] = 0; sv[1] = 0; apply();
    cycle(); cycle();
    src_log.delete();
    slen[0] = 4;
    for (int b = 0; b < 4; b++) begin
      sbeat[0] = b; sl[0] = (b == 3); sd[0] = 8'(8'h30 + b); sv[0] = 1;
      if (b == 2) begin sv[1] = 1; sl[1] = 1; sd[1] = 8'h3F; end
      apply();
      cycle();
      chk("t3_i0_acc", acc[0], 1);
      if (b >= 2) chk("t3_i1_blocked", last_r1, 0);
      if (y_valid) src_log.push_back(int'(y_src));
    end
    sv[0] = 0; apply();
    cycle();
    chk("t3_i1_next", last_r1, 1);
    if (y_valid) src_log.push_back(int'(y_src));
    sv[1] = 0; apply();
    cycle();
    chk("t3_log_len", src_log.size(), 5);
    for (int i = 0; i < src_log.size() && i < 5; i++)
      chk("t3_log_src", src_log[i], (i == 4) ? 1 : 0);

    // Backpressure with a beat in the stage
    sv[0] = 1; sl[0] = 1; slen[0] = 1; sbeat[0] = 0; sd[0] = 8'h41; y_ready = 1;
    apply();
    cycle();
    sd[0] = 8'h42; y_ready = 0; apply();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_hold_data", y_data, 8'h41);
      chk("t4_hold_last", y_last, 1);
      chk("t4_i0_ready", last_r0, 0);
      chk("t4_i1_ready", last_r1, 0);
    end
    y_ready = 1; apply();
    cycle();
    chk("t4_reload_ready", last_r0, 1);
    chk("t4_reload_data", y_data, 8'h42);
    sv[0] = 0; apply();

    // Fixed priority: i0 always wins 2-beat packets
    f_i0_valid = 1; f_i1_valid = 1; f_i1_last = 1; f_i1_data = 8'hEE;
    f_i0_data = 8'h50; f_i0_last = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t5_y_valid", f_y_valid, 1);
      chk("t5_y_src", f_y_src, 0);
      chk("t5_y_data", f_y_data, 8'(8'h50 + k));
      chk("t5_y_last", f_y_last, k % 2);
      chk("t5_busy", f_busy, 1);
      chk("t5_i0_ready", f_i0_ready, 1);
      chk("t5_i1_ready", f_i1_ready, 0);
      f_i0_data = 8'(8'h50 + k + 1);
      f_i0_last = ((k + 1) % 2 == 1);
    end
    f_i0_valid = 0; f_i1_valid = 0;

    // i1 alone, single beat 8'hA5
    cycle(); cycle();
    sv[1] = 1; sd[1] = 8'hA5; sl[1] = 1; slen[1] = 1; sbeat[1] = 0; apply();
    cycle();
    chk("t6_acc", acc[1], 1);
    sv[1] = 0; apply();
    chk("t6_y_valid", y_valid, 1);
    chk("t6_y_data", y_data, 8'hA5);
    chk("t6_y_src", y_src, 1);
    cycle();
    chk("t6_y_valid_clr", y_valid, 0);
    chk("t6_busy_clr", busy, 0);

    // Random multi-beat traffic with random backpressure
    for (int s = 0; s < 2; s++) begin
      sbeat[s] = 0; slen[s] = $urandom_range(1, 4); new_beat(s); sv[s] = 1;
    end
    apply();
    for (int k = 0; k < 400; k++) begin
      cycle();
      rand_advance();
    end

    // Asynchronous reset mid-traffic
    sv[0] = 1; sv[1] = 1; apply();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_i0_ready", i0_ready, 0);
    chk("mid_rst_i1_ready", i1_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1; sbeat[s] = 0; slen[s] = 1; new_beat(s);
    end
    y_ready = 1; apply();
    exp_d = sd[0];
    cycle();
    chk("post_rst_acc0", acc[0], 1);
    chk("post_rst_src", y_src, 0);
    chk("post_rst_data", y_data, exp_d);
    sv[0] = 0; sv[1] = 0; apply();
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
